lsu_mem_port: RTL and testbench

- Load/store execution port for the pipelined CPU, in the MEM stage.
- Consumes the decoder's memory controls: load select (memReg) and byte write enables (dwe 0001/0011/1111 for SB/SH/SW).
- Turns one access into a req/ack transaction on the data-memory bus and stalls the pipeline until it completes.
- Returns byte-aligned, sign- or zero-extended load data to writeback.

---
 rtl/lsu_mem_port.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: MEM-stage load/store port, one req/ack bus access per op.
// Sizes, lane-shifts and extends data; stalls the pipe until ack or timeout.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   req_valid       MEM-stage instruction valid
//   mem_read        load select (priority over dwe)
//   dwe             unshifted store byte enables (0001/0011/1111)
//   funct3          load size/sign select
//   addr, wdata     effective address, unshifted store data
//   stall           hold pipeline (start or BUSY)
//   ld_data         extended load result, held until next load
//   ld_valid        one-cycle load-complete pulse
//   misalign_err    one-cycle misaligned pulse (trap build only)
//   bus_err         one-cycle ack-timeout pulse
//   m_req/m_we      bus request, byte strobes (0 = read)
//   m_addr/m_wdata  word-aligned address, lane-shifted data
//   m_ack/m_rdata   bus acknowledge and read word
//
// Build option: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses;
// otherwise misaligned addresses are forced to natural alignment.
module lsu_mem_port #(
    parameter int ACK_TIMEOUT = 255,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          mem_read,
    input  logic [3:0]    dwe,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic [31:0]   ld_data,
    output logic          ld_valid,
    output logic          misalign_err,
    output logic          bus_err,
    output logic          m_req,
    output logic [3:0]    m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic          m_ack,
    input  logic [31:0]   m_rdata
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, next;

    logic [1:0]    sz;
    logic [1:0]    off;
    logic          is_acc;
    logic          aligned;
    logic          start;
    logic          ack_hit;
    logic          tmo_hit;
    logic [CW-1:0] cnt;
    logic          is_ld_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   lane;
    logic [31:0]   ld_ext;

    // Access size: 00 byte, 01 half, 10 word.
    always_comb begin
        sz = 2'b00;
        if (mem_read)
            sz = funct3[1:0];
        else if (dwe == 4'b1111)
            sz = 2'b10;
        else if (dwe == 4'b0011)
            sz = 2'b01;
    end

    // Byte offset with natural-alignment masking; in the trap build
    // misaligned accesses never start, so the masking is harmless there.
    always_comb begin
        case (sz)
            2'b01:   off = {addr[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = addr[1:0];
        endcase
    end

    assign is_acc = mem_read | (dwe != 4'b0000);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    assign misal = ((sz == 2'b01) & addr[0]) |
                   ((sz == 2'b10) & (addr[1:0] != 2'b00));
    assign aligned = ~misal;
`else
    assign aligned = 1'b1;
    assign misalign_err = 1'b0;
`endif

    assign start   = (state == IDLE) & req_valid & is_acc & aligned;
    assign ack_hit = (state == BUSY) & m_ack & m_req;
    assign tmo_hit = (state == BUSY) & ~m_ack &
                     (cnt == CW'(ACK_TIMEOUT - 1));

    assign lane = m_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b010:  ld_ext = lane;
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next  = state;
        stall = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start)
                    next = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (ack_hit | tmo_hit)
                    next = DONE;
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req    <= 1'b0;
            m_we     <= 4'b0000;
            m_addr   <= '0;
            m_wdata  <= 32'h0;
            ld_data  <= 32'h0;
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
            is_ld_q  <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            cnt      <= '0;
        end else begin
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
            if (start) begin
                m_req   <= 1'b1;
                m_we    <= mem_read ? 4'b0000 : (dwe << off);
                m_addr  <= {addr[AW-1:2], 2'b00};
                m_wdata <= wdata << {off, 3'b000};
                is_ld_q <= mem_read;
                f3_q    <= funct3;
                off_q   <= off;
                cnt     <= '0;
            end
            if (ack_hit) begin
                m_req <= 1'b0;
                if (is_ld_q) begin
                    ld_data  <= ld_ext;
                    ld_valid <= 1'b1;
                end
            end else if (tmo_hit) begin
                m_req   <= 1'b0;
                bus_err <= 1'b1;
                ld_data <= 32'h0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_err <= 1'b0;
        else
            misalign_err <= (state == IDLE) & req_valid &
                            is_acc & misal;
    end
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port with ACK_TIMEOUT = 4.
// Stores, sized loads, ack delay, timeout, misalignment and reset abort.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        mem_read;
    logic [3:0]  dwe;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign_err;
    logic        bus_err;
    logic        m_req;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int tests;
    int fails;

    int          st_cnt;
    int          rq_cnt;
    logic        unstable;
    logic        done;
    logic [31:0] cap_addr;
    logic [3:0]  cap_we;
    logic [31:0] cap_wd;
    logic        d_ldv;
    logic [31:0] d_ld;
    logic        d_berr;
    logic        d_req;

    lsu_mem_port #(
        .ACK_TIMEOUT(4),
        .AW(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .mem_read(mem_read),
        .dwe(dwe),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .stall(stall),
        .ld_data(ld_data),
        .ld_valid(ld_valid),
        .misalign_err(misalign_err),
        .bus_err(bus_err),
        .m_req(m_req),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_ack(m_ack),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase
    // in the IDLE cycle following DONE.
    task automatic access(input string tag,
                          input logic rd,
                          input logic [3:0] we,
                          input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [31:0] rdat,
                          input int ackdly);
        mem_read  = rd;
        dwe       = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        m_rdata   = rdat;
        m_ack     = 1'b0;
        req_valid = 1'b1;
        st_cnt    = 0;
        rq_cnt    = 0;
        unstable  = 1'b0;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall)
                st_cnt++;
            if (c > 0 && !stall) begin
                done   = 1'b1;
                d_ldv  = ld_valid;
                d_ld   = ld_data;
                d_berr = bus_err;
                d_req  = m_req;
            end else begin
                if (m_req) begin
                    if (rq_cnt == 0) begin
                        cap_addr = m_addr;
                        cap_we   = m_we;
                        cap_wd   = m_wdata;
                    end else if (m_addr !== cap_addr ||
                                 m_we !== cap_we ||
                                 m_wdata !== cap_wd) begin
                        unstable = 1'b1;
                    end
                    rq_cnt++;
                    m_ack = (rq_cnt > ackdly);
                end
                @(posedge clk);
                #1;
                m_ack = 1'b0;
            end
        end
        req_valid = 1'b0;
        mem_read  = 1'b0;
        dwe       = 4'b0000;
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        chk({tag, "_unstable"}, {31'h0, unstable}, 32'h0);
        chk({tag, "_done_req"}, {31'h0, d_req}, 32'h0);
        @(posedge clk);
        #1;
        chk({tag, "_idle_stall"}, {31'h0, stall}, 32'h0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        dwe       = 4'b0000;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        m_ack     = 1'b0;
        m_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", {31'h0, m_req}, 32'h0);
        chk("rst_m_we", {28'h0, m_we}, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_misal", {31'h0, misalign_err}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        access("sw", 1'b0, 4'b1111, 3'b010, 32'h1004,
               32'hDEADBEEF, 32'h0, 0);
        chk("sw_addr", cap_addr, 32'h1004);
        chk("sw_we", {28'h0, cap_we}, 32'hF);
        chk("sw_wdata", cap_wd, 32'hDEADBEEF);
        chk("sw_stall_cnt", st_cnt, 2);
        chk("sw_req_cnt", rq_cnt, 1);
        chk("sw_ldv", {31'h0, d_ldv}, 32'h0);

        access("sb", 1'b0, 4'b0001, 3'b000, 32'h2003,
               32'h000000A5, 32'h0, 0);
        chk("sb_addr", cap_addr, 32'h2000);
        chk("sb_we", {28'h0, cap_we}, 32'h8);
        chk("sb_wdata", cap_wd, 32'hA5000000);

        access("lh", 1'b1, 4'b0000, 3'b001, 32'h3002,
               32'h0, 32'h80F17F00, 0);
        chk("lh_data", d_ld, 32'hFFFF80F1);
        chk("lh_ldv", {31'h0, d_ldv}, 32'h1);
        chk("lh_we", {28'h0, cap_we}, 32'h0);
        chk("lh_addr", cap_addr, 32'h3000);
        chk("lh_ldv_pulse", {31'h0, ld_valid}, 32'h0);
        chk("lh_hold", ld_data, 32'hFFFF80F1);

        access("lhu", 1'b1, 4'b0000, 3'b101, 32'h3002,
               32'h0, 32'h80F17F00, 0);
        chk("lhu_data", d_ld, 32'h000080F1);
        chk("lhu_ldv", {31'h0, d_ldv}, 32'h1);

        access("lb", 1'b1, 4'b0000, 3'b000, 32'h3002,
               32'h0, 32'h80F17F00, 0);
        chk("lb_data", d_ld, 32'hFFFFFFF1);
        chk("lb_ldv", {31'h0, d_ldv}, 32'h1);

        access("lbu", 1'b1, 4'b0000, 3'b100, 32'h3002,
               32'h0, 32'h80F17F00, 2);
        chk("lbu_data", d_ld, 32'h000000F1);
        chk("lbu_ldv", {31'h0, d_ldv}, 32'h1);
        chk("lbu_stall_cnt", st_cnt, 4);
        chk("lbu_req_cnt", rq_cnt, 3);

        access("sh", 1'b0, 4'b0011, 3'b001, 32'h2002,
               32'h00001234, 32'h0, 0);
        chk("sh_we", {28'h0, cap_we}, 32'hC);
        chk("sh_wdata", cap_wd, 32'h12340000);
        chk("sh_hold", d_ld, 32'h000000F1);

        access("f3_011", 1'b1, 4'b0000, 3'b011, 32'h3000,
               32'h0, 32'h80F17F00, 0);
        chk("f3_011_data", d_ld, 32'h0);

        req_valid = 1'b1;
        mem_read  = 1'b0;
        dwe       = 4'b0000;
        #1;
        chk("nop_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("nop_req", {31'h0, m_req}, 32'h0);
        chk("nop_stall2", {31'h0, stall}, 32'h0);
        req_valid = 1'b0;

        access("tmo", 1'b1, 4'b0000, 3'b010, 32'h5000,
               32'h0, 32'h11111111, 1000);
        chk("tmo_req_cnt", rq_cnt, 4);
        chk("tmo_bus_err", {31'h0, d_berr}, 32'h1);
        chk("tmo_ld_data", d_ld, 32'h0);
        chk("tmo_ldv", {31'h0, d_ldv}, 32'h0);
        chk("tmo_err_pulse", {31'h0, bus_err}, 32'h0);
        chk("tmo_req_idle", {31'h0, m_req}, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h4001;
        req_valid = 1'b1;
        #1;
        chk("mis_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("mis_err", {31'h0, misalign_err}, 32'h1);
        chk("mis_req", {31'h0, m_req}, 32'h0);
        req_valid = 1'b0;
        mem_read  = 1'b0;
        @(posedge clk);
        #1;
        chk("mis_err_pulse", {31'h0, misalign_err}, 32'h0);
        chk("mis_req2", {31'h0, m_req}, 32'h0);
`else
        access("mis", 1'b1, 4'b0000, 3'b010, 32'h4001,
               32'h0, 32'hCAFEF00D, 0);
        chk("mis_addr", cap_addr, 32'h4000);
        chk("mis_data", d_ld, 32'hCAFEF00D);
        chk("mis_ldv", {31'h0, d_ldv}, 32'h1);
        chk("mis_err_tied", {31'h0, misalign_err}, 32'h0);
`endif

        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h20;
        m_ack     = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid_busy_req", {31'h0, m_req}, 32'h1);
        req_valid = 1'b0;
        mem_read  = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rmid_req", {31'h0, m_req}, 32'h0);
        chk("rmid_stall", {31'h0, stall}, 32'h0);
        chk("rmid_addr", m_addr, 32'h0);
        chk("rmid_ld_data", ld_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rmid_no_ldv", {31'h0, ld_valid}, 32'h0);
        chk("rmid_no_berr", {31'h0, bus_err}, 32'h0);

        access("post", 1'b1, 4'b0000, 3'b010, 32'h10,
               32'h0, 32'h12345678, 0);
        chk("post_addr", cap_addr, 32'h10);
        chk("post_data", d_ld, 32'h12345678);
        chk("post_ldv", {31'h0, d_ldv}, 32'h1);
        chk("post_stall_cnt", st_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
